// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush sequencer for a 5-stage pipeline with memory-wait watchdog.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters (tied to zero otherwise).
module hazard_control_unit #(
  parameter int WAIT_LIMIT = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  Rs1_Addr_D,
  input  logic [4:0]  Rs2_Addr_D,
  input  logic [4:0]  Rd_Addr_E,
  input  logic        Mem_Read_E,
  input  logic        Branch_Taken_E,
  input  logic        IMem_Ready,
  input  logic        DMem_Req_M,
  input  logic        DMem_Ready,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Bus_Err,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [1:0] {RUN, FETCH_WAIT, DATA_WAIT, ERROR} state_t;
  state_t state, nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic redirect_pend, pend_nxt;
  logic dw, fw, lu, discard, waiting, active;
  assign dw = DMem_Req_M & ~DMem_Ready;
  assign fw = ~IMem_Ready;
  assign lu = Mem_Read_E & (Rd_Addr_E != 5'd0) & ((Rd_Addr_E == Rs1_Addr_D) | (Rd_Addr_E == Rs2_Addr_D));
  // the wrong-path fetch returning after a redirect is thrown away
  assign discard = redirect_pend & IMem_Ready;
  assign waiting = (state == FETCH_WAIT) | (state == DATA_WAIT);
  assign active = RST_N & (state != ERROR) & ~dw;
  assign Bus_Err = state == ERROR;
  always_comb begin
    Stall_F = 1'b1;
    Stall_D = 1'b1;
    Stall_E = 1'b1;
    Stall_M = 1'b1;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    if (active) begin
      Stall_F = ~Branch_Taken_E & (lu | fw) & ~discard;
      Stall_D = ~Branch_Taken_E & lu;
      Stall_E = 1'b0;
      Stall_M = 1'b0;
      Flush_D = Branch_Taken_E | (fw & ~lu) | discard;
      Flush_E = Branch_Taken_E | lu;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      RUN:        nxt = dw ? DATA_WAIT : fw ? FETCH_WAIT : RUN;
      FETCH_WAIT: nxt = dw ? DATA_WAIT : IMem_Ready ? RUN : FETCH_WAIT;
      DATA_WAIT:  nxt = DMem_Ready ? (fw ? FETCH_WAIT : RUN) : DATA_WAIT;
      ERROR:      nxt = ERROR;
    endcase
    if (waiting && nxt == state && wait_cnt == CW'(WAIT_LIMIT - 1)) nxt = ERROR;
    cnt_nxt = (waiting && nxt == state) ? wait_cnt + 1'b1 : '0;
    pend_nxt = dw ? redirect_pend : Branch_Taken_E ? fw : IMem_Ready ? 1'b0 : redirect_pend;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      wait_cnt <= '0;
      redirect_pend <= 1'b0;
    end else begin
      state <= nxt;
      wait_cnt <= cnt_nxt;
      redirect_pend <= pend_nxt;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      Stall_Count <= Stall_Count + {31'd0, Stall_F};
      Flush_Count <= Flush_Count + {31'd0, Flush_D | Flush_E};
    end
  end
`else
  assign Stall_Count = 32'h0;
  assign Flush_Count = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench, directed spec scenarios plus random traffic vs a behavioural model.
module tb_hazard_control_unit;
  localparam int WL = 8;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [4:0] rs1 = 5'd1, rs2 = 5'd2, rd = 5'd3;
  logic mr = 1'b0, br = 1'b0, ir = 1'b1, dreq = 1'b0, drdy = 1'b0;
  logic sf, sd, se, sm, fd, fe, berr;
  logic [31:0] scnt, fcnt;
  hazard_control_unit #(.WAIT_LIMIT(WL)) dut (
    .CLK(CLK), .RST_N(RST_N), .Rs1_Addr_D(rs1), .Rs2_Addr_D(rs2), .Rd_Addr_E(rd),
    .Mem_Read_E(mr), .Branch_Taken_E(br), .IMem_Ready(ir), .DMem_Req_M(dreq), .DMem_Ready(drdy),
    .Stall_F(sf), .Stall_D(sd), .Stall_E(se), .Stall_M(sm), .Flush_D(fd), .Flush_E(fe),
    .Bus_Err(berr), .Stall_Count(scnt), .Flush_Count(fcnt)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [5:0]  ctrl;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  // model: mode 0=running, 1=waiting on fetch, 2=waiting on data; waits = completed cycles in this wait
  bit m_err, m_pend;
  int m_mode, m_waits;
  logic [31:0] m_sc, m_fc;
  task automatic model_reset();
    m_err = 0; m_pend = 0; m_mode = 0; m_waits = 0; m_sc = 0; m_fc = 0;
  endtask
  // ctrl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
  function automatic exp_t predict();
    exp_t e;
    bit d_wait, f_wait, load_use;
    d_wait = dreq && !drdy;
    f_wait = !ir;
    load_use = mr && rd != 0 && (rd == rs1 || rd == rs2);
    if (!RST_N || m_err || d_wait) e.ctrl = 6'b111100;
    else if (br) e.ctrl = 6'b000011;
    else begin
      e.ctrl = load_use ? 6'b110001 : f_wait ? 6'b100010 : 6'b000000;
      if (m_pend && ir) e.ctrl = (e.ctrl & 6'b011111) | 6'b000010;
    end
    e.err = RST_N && m_err;
    e.sc = m_sc;
    e.fc = m_fc;
    return e;
  endfunction
  task automatic advance(input logic [5:0] c);
    int nm;
    bit d_wait;
    d_wait = dreq && !drdy;
`ifdef HAZARD_PERF_CNT_EN
    if (c[5]) m_sc = m_sc + 1;
    if (c[1] || c[0]) m_fc = m_fc + 1;
`endif
    if (m_err) return;
    if (!d_wait) m_pend = br ? !ir : (ir ? 0 : m_pend);
    case (m_mode)
      0: nm = d_wait ? 2 : !ir ? 1 : 0;
      1: nm = d_wait ? 2 : ir ? 0 : 1;
      default: nm = drdy ? (!ir ? 1 : 0) : 2;
    endcase
    if (nm != 0 && nm == m_mode) begin
      m_waits++;
      if (m_waits >= WL) m_err = 1;
    end else m_waits = 0;
    m_mode = nm;
  endtask
  task automatic apply(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic m, input logic bt, input logic i, input logic dq, input logic dr);
    exp_t e;
    @(negedge CLK);
    RST_N = r; rs1 = a; rs2 = b; rd = c; mr = m; br = bt; ir = i; dreq = dq; drdy = dr;
    if (!r) model_reset();
    e = predict();
    q.push_back(e);
    @(posedge CLK);
    if (RST_N) advance(e.ctrl);
  endtask
  task automatic idle(input int n);
    repeat (n) apply(1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if ({sf, sd, se, sm, fd, fe} !== e.ctrl) begin
          miscompares++;
          $display("FAIL ctrl t=%0t got %b want %b", $time, {sf, sd, se, sm, fd, fe}, e.ctrl);
        end
        if (berr !== e.err) begin
          miscompares++;
          $display("FAIL bus_err t=%0t got %b want %b", $time, berr, e.err);
        end
        if (scnt !== e.sc || fcnt !== e.fc) begin
          miscompares++;
          $display("FAIL perf t=%0t got %0d/%0d want %0d/%0d", $time, scnt, fcnt, e.sc, e.fc);
        end
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) apply(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
    idle(2);
    apply(1, 5'd7, 5'd5, 5'd5, 1, 0, 1, 0, 0);
    idle(1);
    apply(1, 5'd0, 5'd9, 5'd0, 1, 0, 1, 0, 0);
    idle(1);
    apply(1, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
    repeat (3) apply(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
    idle(2);
    repeat (4) apply(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 0);
    apply(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 1);
    idle(1);
    repeat (12) apply(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
    idle(3);
    apply(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
    idle(1);
    repeat (5) apply(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
    apply(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      apply(1, 5'd4, 5'd8, 5'd4, 1, 0, 1, 0, 0);
      idle(1);
    end
    repeat (2) begin
      apply(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0);
      idle(1);
    end
    for (int k = 0; k < 2000; k++)
      apply($urandom_range(0, 199) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge CLK);
    #4;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
